// File: rtl/serial_subtractor_32_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encoding, default geometry
// and the digit-count helper.
package serial_subtractor_32_pkg;

  localparam int SUB_WIDTH = 32;
  localparam int SUB_DIGIT = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_subtractor_32_sub_slice.sv
// Combinational DIGIT-bit subtract slice; borrow is carried as the inverted carry
// of a + ~b + ~brw_in.
module sub_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             brw_in,
  output logic [DIGIT-1:0] d,
  output logic             brw_out
);

  logic [DIGIT:0] sum;

  always_comb begin
    sum     = {1'b0, a_d} + {1'b0, ~b_d} + {{DIGIT{1'b0}}, ~brw_in};
    d       = sum[DIGIT-1:0];
    brw_out = ~sum[DIGIT];
  end

endmodule

// File: rtl/serial_subtractor_32.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per cycle LSB first,
// start/busy/done handshake, WIDTH/DIGIT cycles per operation.
module serial_subtractor_32
  import serial_subtractor_32_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int DIGIT = SUB_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t                   state;
  logic [WIDTH-1:0]         a_sr;
  logic [WIDTH-1:0]         b_sr;
  // Holds the result digits produced so far; the newest digit enters at the top.
  logic [WIDTH-DIGIT-1:0]   acc;
  logic                     brw;
  logic [CW-1:0]            cnt;
  logic [DIGIT-1:0]         d_dig;
  logic                     brw_nxt;

  sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a_d     (a_sr[DIGIT-1:0]),
    .b_d     (b_sr[DIGIT-1:0]),
    .brw_in  (brw),
    .d       (d_dig),
    .brw_out (brw_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr <= a_sr >> DIGIT;
          b_sr <= b_sr >> DIGIT;
          acc  <= {d_dig, acc[WIDTH-DIGIT-1:DIGIT]};
          brw  <= brw_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= {d_dig, acc};
            bout  <= brw_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_32.sv
// Self-checking bench for serial_subtractor_32: scoreboard of expected {bout, diff}
// popped on every done pulse, plus scenario tasks for handshake and reset behaviour.
module tb_serial_subtractor_32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic [31:0] diff;
  logic        bout;
  logic        busy;
  logic        done;

  int          test_cnt = 0;
  int          fail_cnt = 0;
  int          done_cnt = 0;
  logic [32:0] exp_q[$];
  logic [32:0] prev_res = '0;

  serial_subtractor_32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference: the ripple adder fed with a, ~b, ~bin; borrow is the inverted carry.
  function automatic logic [32:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic bi);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, ~y} + {32'd0, ~bi};
    return {~s[32], s[31:0]};
  endfunction

  // Scoreboard monitor, sampling 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      prev_res = {bout, diff};
    end else begin
      test_cnt++;
      if (!done && {bout, diff} !== prev_res) begin
        fail_cnt++;
        $display("FAIL result_stable: got %h, held %h", {bout, diff}, prev_res);
      end
      if (done) begin
        done_cnt++;
        test_cnt++;
        if (busy !== 1'b0) begin
          fail_cnt++;
          $display("FAIL done_busy_excl: busy=%b while done=1, required 0", busy);
        end
        test_cnt++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL scoreboard_unexpected_done: got %h, no result expected", {bout, diff});
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if ({bout, diff} !== e) begin
            fail_cnt++;
            $display("FAIL scoreboard: got bout=%b diff=%h, required bout=%b diff=%h",
                     bout, diff, e[32], e[31:0]);
          end
        end
      end
      prev_res = {bout, diff};
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic bi, input logic [32:0] e);
    @(negedge clk);
    start = 1'b1; a = x; b = y; bin = bi;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (cyc < limit && !ok) begin
      @(negedge clk);
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_cnt++;
    if ({diff, bout, busy, done} !== 35'd0) begin
      fail_cnt++;
      $display("FAIL reset_state: diff=%h bout=%b busy=%b done=%b, required all 0", diff, bout, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    int cyc;
    // T1 with latency check
    issue(32'h0000_0000, 32'h0000_0001, 1'b0, {1'b1, 32'hffff_ffff});
    test_cnt++;
    if (busy !== 1'b1) begin
      fail_cnt++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    wait_done(20, ok, cyc);
    test_cnt++;
    if (!ok || cyc != 8) begin
      fail_cnt++;
      $display("FAIL t1_latency: done seen=%0d after %0d cycles, required 8", ok, cyc);
    end
    // T2
    issue(32'ha420_2b00, 32'h0f01_da11, 1'b1, {1'b0, 32'h951e_50ee});
    wait_done(20, ok, cyc);
    test_cnt++;
    if (!ok) begin fail_cnt++; $display("FAIL t2_timeout: no done, required done"); end
    // T3
    issue(32'h1234_5678, 32'h1234_5678, 1'b1, {1'b1, 32'hffff_ffff});
    wait_done(20, ok, cyc);
    issue(32'h1234_5678, 32'h1234_5678, 1'b0, {1'b0, 32'h0000_0000});
    wait_done(20, ok, cyc);
    test_cnt++;
    if (!ok || diff !== 32'h0 || bout !== 1'b0) begin
      fail_cnt++;
      $display("FAIL t3_equal: diff=%h bout=%b, required 00000000/0", diff, bout);
    end
  endtask

  task automatic test_start_while_busy;
    bit ok;
    int cyc;
    int d0;
    d0 = done_cnt;
    issue(32'ha420_2b00, 32'h0f01_da11, 1'b1, {1'b0, 32'h951e_50ee});
    repeat (2) @(negedge clk);
    start = 1'b1; a = 32'hffff_ffff; b = 32'h0; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, ok, cyc);
    repeat (12) @(negedge clk);
    test_cnt++;
    if (done_cnt - d0 != 1) begin
      fail_cnt++;
      $display("FAIL busy_start_ignored: %0d done pulses, required 1", done_cnt - d0);
    end
    test_cnt++;
    if (diff !== 32'h951e_50ee || bout !== 1'b0) begin
      fail_cnt++;
      $display("FAIL busy_start_result: diff=%h bout=%b, required 951e50ee/0", diff, bout);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    int cyc;
    int d0;
    issue(32'h8765_4321, 32'h1111_1111, 1'b0, {1'b0, 32'h7654_3210});
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    test_cnt++;
    if ({diff, bout, busy, done} !== 35'd0) begin
      fail_cnt++;
      $display("FAIL async_reset: diff=%h bout=%b busy=%b done=%b, required all 0", diff, bout, busy, done);
    end
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    test_cnt++;
    if (done_cnt != d0) begin
      fail_cnt++;
      $display("FAIL reset_discard: %0d done pulses after reset, required 0", done_cnt - d0);
    end
    issue(32'h0000_0005, 32'h0000_0007, 1'b0, {1'b1, 32'hffff_fffe});
    wait_done(20, ok, cyc);
    test_cnt++;
    if (!ok || cyc != 8) begin
      fail_cnt++;
      $display("FAIL post_reset_op: done seen=%0d after %0d cycles, required 8", ok, cyc);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int cyc;
    issue(32'hdead_beef, 32'h0bad_f00d, 1'b0, ref_sub(32'hdead_beef, 32'h0bad_f00d, 1'b0));
    wait_done(20, ok, cyc);
    start = 1'b1; a = 32'h0000_0010; b = 32'h0000_0020; bin = 1'b1;
    exp_q.push_back({1'b1, 32'hffff_ffef});
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 20 && !done) begin
      @(negedge clk);
      cyc++;
    end
    test_cnt++;
    if (!ok || !done || cyc != 9) begin
      fail_cnt++;
      $display("FAIL back_to_back: second done %0d cycles after first, required 9", cyc);
    end
  endtask

  task automatic test_random;
    bit ok;
    int cyc;
    int misses;
    logic [31:0] x, y;
    logic bi;
    misses = 0;
    for (int i = 0; i < 1000; i++) begin
      x = $urandom();
      y = (i % 10 == 0) ? x : $urandom();
      bi = 1'($urandom_range(0, 1));
      issue(x, y, bi, ref_sub(x, y, bi));
      wait_done(20, ok, cyc);
      if (!ok) misses++;
    end
    repeat (3) @(negedge clk);
    test_cnt++;
    if (misses != 0 || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL random_drain: %0d timeouts, %0d pending, required 0/0", misses, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_while_busy();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
